// File: rtl/dual_grant_pkg.sv
// Shared types and constants for the dual grant decoder.
package dual_grant_pkg;

  localparam int N_LINES     = 12;
  localparam int IDX_W       = 4;
  localparam int HOLD_CYCLES = 4;

  // Grant sequencing: wait for work, drive a grant, then one idle gap cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // One transaction from the upstream priority encoder.
  typedef struct packed {
    logic [IDX_W-1:0] y1;
    logic             v1;
    logic [IDX_W-1:0] y2;
    logic             v2;
  } pair_t;

endpackage

// File: rtl/dual_grant_decoder_index_decoder.sv
// Turns one encoded index plus its valid bit into a one-hot line vector.
// Indices at or above N give no line and raise out_of_range instead.
module index_decoder #(
  parameter int N  = 12,
  parameter int IW = 4
) (
  input  logic [IW-1:0] idx,
  input  logic          valid,
  output logic [N-1:0]  onehot,
  output logic          out_of_range
);

  // One-hot decode of a valid, in-range index.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (valid && (32'(idx) == 32'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

  assign out_of_range = valid && (32'(idx) >= 32'(N));

endmodule

// File: rtl/dual_grant_decoder.sv
// Decodes (y1/v1, y2/v2) index pairs into a held one-hot grant vector.
// Each non-empty pair drives grant for HOLD cycles, followed by one zero
// gap cycle. A single pending entry lets upstream queue the next pair.
//
// Handshake: a pair transfers on a rising edge where in_valid && in_ready.
// in_ready is low only while the pending entry is occupied; in_valid may be
// raised or dropped freely, nothing is held by the block until it transfers.
module dual_grant_decoder
  import dual_grant_pkg::*;
#(
  parameter int N    = N_LINES,
  parameter int IW   = IDX_W,
  parameter int HOLD = HOLD_CYCLES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] y1,
  input  logic          v1,
  input  logic [IW-1:0] y2,
  input  logic          v2,
  output logic [N-1:0]  grant,
  output logic          grant_active,
  output logic          err,
  output logic [1:0]    fsm_state
);

  localparam int            CW        = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  hold_q;
  logic [N-1:0]   grant_reg;
  logic           pend_full;
  logic [N-1:0]   pend_vec;
  logic           err_q;

  logic [N-1:0]   onehot1;
  logic [N-1:0]   onehot2;
  logic           oor1;
  logic           oor2;
  logic [N-1:0]   dec_vec;
  logic           nonempty;
  logic           accept;
  logic           load_pend;
  logic           load_in;
  logic           write_pend;

  index_decoder #(.N(N), .IW(IW)) u_dec1 (
    .idx          (y1),
    .valid        (v1),
    .onehot       (onehot1),
    .out_of_range (oor1)
  );

  index_decoder #(.N(N), .IW(IW)) u_dec2 (
    .idx          (y2),
    .valid        (v2),
    .onehot       (onehot2),
    .out_of_range (oor2)
  );

  // Duplicate indices collapse naturally in the OR.
  assign dec_vec  = onehot1 | onehot2;
  assign nonempty = |dec_vec;
  assign in_ready = !pend_full;
  assign accept   = in_valid && in_ready;

  // The pending entry always wins over a fresh pair when the FSM can load.
  assign load_pend  = pend_full && ((state_q == IDLE) || (state_q == GAP));
  assign load_in    = accept && nonempty && (state_q == IDLE) && !pend_full;
  // Empty pairs are consumed without touching the pending entry.
  assign write_pend = accept && nonempty && (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_pend || load_in) state_d = GRANT;
      GRANT:   if (hold_q == '0) state_d = GAP;
      GAP:     state_d = pend_full ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold counter, grant/pending registers and the error pulse flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      grant_reg <= '0;
      pend_full <= 1'b0;
      pend_vec  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && (oor1 || oor2);

      if (load_pend) begin
        grant_reg <= pend_vec;
      end else if (load_in) begin
        grant_reg <= dec_vec;
      end

      if (load_pend || load_in) begin
        hold_q <= HOLD_LOAD;
      end else if ((state_q == GRANT) && (hold_q != '0)) begin
        hold_q <= hold_q - CW'(1);
      end

      if (write_pend) begin
        pend_full <= 1'b1;
        pend_vec  <= dec_vec;
      end else if (load_pend) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Outputs derived from registered state only.
  always_comb begin
    grant        = '0;
    grant_active = 1'b0;
    if (state_q == GRANT) begin
      grant        = grant_reg;
      grant_active = 1'b1;
    end
  end

  assign err       = err_q;
  assign fsm_state = state_q;

endmodule

// File: doc/dual_grant_decoder.md
# dual_grant_decoder

Consumer of the dual-priority encoder output: accepts a pair of encoded grant indices (y1/v1, y2/v2) per transaction and decodes it back into a 12-line one-hot grant vector. Each grant is held for a fixed number of cycles, followed by a one-cycle idle gap. A one-entry pending buffer lets the upstream issue the next pair while the current one is being served. The block sits between the request encoder and the 12 serviced resources.

## Interface
- N, 12, number of request/grant lines
- IW, 4, index width (IW ≥ clog2(N))
- HOLD, 4, cycles each grant is asserted (HOLD ≥ 1)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers a pair
- in_ready  out  1  block can accept a pair
- y1  in  IW  first-priority index
- v1  in  1  y1 valid
- y2  in  IW  second-priority index
- v2  in  1  y2 valid
- grant  out  N  decoded grant lines; up to two bits set
- grant_active  out  1  grant phase in progress
- err  out  1  one-cycle pulse: accepted pair had a valid index ≥ N

## Operation
- The transfer occurs on a rising edge with in_valid && in_ready.
- in_ready = !pend_full (combinational from a register).
- Decode rule: grant = (v1 && y1<N ? 1<<y1 : 0) | (v2 && y2<N ? 1<<y2 : 0).
  - If y1 == y2 with both valid, a single bit is set; this is not an error.
  - An out-of-range valid index contributes no bit and pulses err the cycle after acceptance.
- Empty pair: a pair whose decoded vector is zero (v1 = v2 = 0, or all valid indices out of range) is consumed. It produces no grant phase and is never buffered.
- FSM states:
  - IDLE:
    - An accepted non-empty pair loads grant_reg, and the FSM goes to GRANT with hold_cnt = HOLD-1.
    - A pending entry, if present, takes priority over the input. It is loaded the same way, and pending is cleared.
  - GRANT:
    - grant = grant_reg and grant_active = 1.
    - hold_cnt decrements each cycle. At hold_cnt = 0 the FSM goes to GAP.
  - GAP:
    - grant = 0 and grant_active = 0 for exactly one cycle.
    - If pending is full, the FSM goes to GRANT with the pending entry; otherwise it goes to IDLE.
- Pending buffer:
  - A non-empty pair accepted while the FSM is not IDLE, or while IDLE with pending full, is written to pending. The second case cannot occur, because in_ready is low.
  - If pending drains on the same edge that a new pair is accepted, the new pair is written into pending.
- hold_cnt width is clog2(HOLD+1). It never wraps below 0.

## Timing
- Reset (asynchronous, reset_n = 0):
  - State goes to IDLE.
  - grant = 0, grant_active = 0, err = 0, pend_full = 0, so in_ready = 1.
  - Takes effect immediately, including mid-grant. Any pending entry is discarded.
- Latency: a pair accepted in IDLE on edge k produces grant and grant_active in cycle k+1, lasting HOLD cycles.
- Back-to-back pairs: grant phases are separated by exactly one zero GAP cycle. The period is HOLD+1 cycles per pair.
- All outputs except in_ready are registered.
- err is asserted for exactly one cycle per offending accepted pair. It is independent of the grant phase and also fires for pairs that turn out empty.

## Structure
- Package dual_grant_pkg:
  - Constants N_LINES = 12 and IDX_W = 4.
  - typedef enum state_t {IDLE, GRANT, GAP}.
  - typedef struct packed pair_t {y1, v1, y2, v2}.
- Sub-module index_decoder: combinational, index + valid → N-bit one-hot plus out_of_range flag. It is instantiated twice; grant_next is the OR of the two outputs.
- The top level holds the FSM, hold_cnt, grant_reg, pending register, and err flop.

## Test plan
- Reset, then a pair y1=3/v1=1, y2=7/v2=1 in IDLE → grant = 12'h088 for cycles k+1..k+4, then 0. grant_active mirrors this and in_ready stays 1.
- Duplicate and single pairs:
  - y1=5, y2=5, both valid → grant = 12'h020.
  - v1=1 y1=0, v2=0 → grant = 12'h001.
- Out of range: y1=13/v1=1, y2=2/v2=1 → err pulses once at k+1 and grant = 12'h004.
  - y1=14/v1=1, v2=0 → err pulse, no grant phase, and the FSM stays in IDLE.
- Back-to-back: three pairs offered continuously (bits 0, 11, 6) → in_ready drops while pending is full.
  - Grants appear as 001 (4 cycles), 0, 800 (4 cycles), 0, 040 (4 cycles), 0.
  - No pair is lost or duplicated.
- Reset mid-operation: reset_n low during the 2nd GRANT cycle with pending full → grant = 0 and in_ready = 1 immediately. After release, no stale grant appears.
- HOLD=1 build: back-to-back pairs give single-cycle grants alternating with single-cycle gaps.
